mem_bus_bridge: RTL and testbench



---
 rtl/mem_bus_bridge.sv | 145 ++++++++++++++
 tb/tb_mem_bus_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// Bridge from one multicycle-core memory request to a valid/ready memory bus, with a timeout error.
// Define MEM_ALIGN_CHECK_EN to reject requests whose address is not word aligned.
module mem_bus_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    output logic              core_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RESP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                bus_valid_q, bus_valid_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                core_ready_q, core_ready_d;
    logic                core_err_q, core_err_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic                timeout_hit;

    // A wait of TIMEOUT cycles in ADDR or RESP without progress ends in ERR.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        core_rdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (core_req) begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (core_addr[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        bus_we_d    = core_we;
                        bus_addr_d  = core_addr;
                        bus_wdata_d = core_wdata;
                        cnt_d       = '0;
                        state_d     = S_ADDR;
                    end
`else
                    bus_we_d    = core_we;
                    bus_addr_d  = core_addr;
                    bus_wdata_d = core_wdata;
                    cnt_d       = '0;
                    state_d     = S_ADDR;
`endif
                end
            end
            S_ADDR: begin
                if (bus_ready) begin
                    cnt_d   = '0;
                    state_d = bus_we_q ? S_DONE : S_RESP;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (bus_rvalid) begin
                    core_rdata_d = bus_rdata;
                    state_d      = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        bus_valid_d  = (state_d == S_ADDR);
        core_ready_d = (state_d == S_DONE) || (state_d == S_ERR);
        core_err_d   = (state_d == S_ERR);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bus_valid_q  <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            core_ready_q <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_valid_q  <= bus_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            core_ready_q <= core_ready_d;
            core_err_q   <= core_err_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign bus_valid  = bus_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign core_ready = core_ready_q;
    assign core_err   = core_err_q;
    assign core_rdata = core_rdata_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge (TIMEOUT=4); inputs change and outputs are sampled 1ns after each rising edge.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_err;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .core_err   (core_err),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int vcnt, rdy_at, first_rdy, second_v;
    logic        err_seen;
    logic [31:0] rd_seen, addr2;

    initial begin
        reset = 1'b1; core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        tick(); tick();
        check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rst_core_ready", {31'd0, core_ready}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Write 0xDEADBEEF to 0x100 with bus_ready tied high
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'hDEADBEEF; bus_ready = 1'b1;
        tick();
        core_req = 1'b0;
        check("wr_valid_n1", {31'd0, bus_valid}, 32'd1);
        check("wr_addr_n1", bus_addr, 32'h100);
        check("wr_data_n1", bus_wdata, 32'hDEADBEEF);
        check("wr_we_n1", {31'd0, bus_we}, 32'd1);
        check("wr_ready_n1", {31'd0, core_ready}, 32'd0);
        tick();
        check("wr_valid_n2", {31'd0, bus_valid}, 32'd0);
        check("wr_ready_n2", {31'd0, core_ready}, 32'd1);
        check("wr_err_n2", {31'd0, core_err}, 32'd0);
        check("wr_rdata_n2", core_rdata, 32'd0);
        bus_ready = 1'b0;
        tick();
        check("wr_ready_n3", {31'd0, core_ready}, 32'd0);

        // Read 0x200: three wait cycles, then handshake exactly at the timeout limit
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h200;
        tick();
        core_req = 1'b0; core_addr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rd_wait_valid%0d", i), {31'd0, bus_valid}, 32'd1);
            check($sformatf("rd_wait_addr%0d", i), bus_addr, 32'h200);
            tick();
        end
        check("rd_hs_valid", {31'd0, bus_valid}, 32'd1);
        check("rd_hs_addr", bus_addr, 32'h200);
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0BAD0;
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        check("rd_resp_valid", {31'd0, bus_valid}, 32'd0);
        check("rd_resp_ready", {31'd0, core_ready}, 32'd0);
        tick();
        check("rd_resp2_ready", {31'd0, core_ready}, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        tick();
        bus_rvalid = 1'b0; bus_rdata = '0;
        check("rd_done_ready", {31'd0, core_ready}, 32'd1);
        check("rd_done_err", {31'd0, core_err}, 32'd0);
        check("rd_done_rdata", core_rdata, 32'h12345678);
        tick();
        check("rd_after_ready", {31'd0, core_ready}, 32'd0);
        check("rd_after_rdata", core_rdata, 32'd0);

        // Timeout: bus_ready stuck low
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h400;
        vcnt = 0; rdy_at = 0; err_seen = 1'b0; rd_seen = 32'hFFFF_FFFF;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) core_req = 1'b0;
            if (bus_valid) vcnt++;
            if (core_ready && rdy_at == 0) begin
                rdy_at = c; err_seen = core_err; rd_seen = core_rdata;
            end
        end
        check("to_valid_cycles", vcnt, 32'd4);
        check("to_ready_cycle", rdy_at, 32'd5);
        check("to_err", {31'd0, err_seen}, 32'd1);
        check("to_rdata", rd_seen, 32'd0);
        check("to_idle_ready", {31'd0, core_ready}, 32'd0);

        // Reset while in RESP, then a late rvalid
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40; bus_ready = 1'b1;
        tick();
        core_req = 1'b0;
        check("rr_valid", {31'd0, bus_valid}, 32'd1);
        tick();
        bus_ready = 1'b0;
        check("rr_in_resp", {31'd0, bus_valid}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_bus_valid", {31'd0, bus_valid}, 32'd0);
        check("rr_bus_we", {31'd0, bus_we}, 32'd0);
        check("rr_bus_addr", bus_addr, 32'd0);
        check("rr_bus_wdata", bus_wdata, 32'd0);
        check("rr_core_ready", {31'd0, core_ready}, 32'd0);
        check("rr_core_err", {31'd0, core_err}, 32'd0);
        check("rr_core_rdata", core_rdata, 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        vcnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (core_ready || bus_valid) vcnt++;
        end
        bus_rvalid = 1'b0; bus_rdata = '0;
        check("rr_late_rvalid", vcnt, 32'd0);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'hA5A5_0001; bus_ready = 1'b1;
        tick();
        core_req = 1'b0;
        check("rr_next_valid", {31'd0, bus_valid}, 32'd1);
        check("rr_next_addr", bus_addr, 32'h80);
        tick();
        bus_ready = 1'b0;
        check("rr_next_ready", {31'd0, core_ready}, 32'd1);
        check("rr_next_err", {31'd0, core_err}, 32'd0);
        tick();

        // core_req held high across two writes; core_addr changes mid-transaction
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'h11; bus_ready = 1'b1;
        first_rdy = 0; second_v = 0; addr2 = '0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) begin
                core_addr = 32'h20; core_wdata = 32'h22;
            end
            if (c == 2) check("b2b_addr_hold", bus_addr, 32'h10);
            if (core_ready && first_rdy == 0) first_rdy = c;
            if (bus_valid && c > 1 && second_v == 0) begin
                second_v = c; addr2 = bus_addr; core_req = 1'b0;
            end
        end
        bus_ready = 1'b0;
        check("b2b_first_ready", first_rdy, 32'd2);
        check("b2b_gap", second_v - first_rdy, 32'd2);
        check("b2b_addr2", addr2, 32'h20);

        // Unaligned read at 0x102
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h102;
        tick();
        core_req = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        check("al_valid", {31'd0, bus_valid}, 32'd0);
        check("al_ready", {31'd0, core_ready}, 32'd1);
        check("al_err", {31'd0, core_err}, 32'd1);
        check("al_rdata", core_rdata, 32'd0);
        tick();
        check("al_idle_valid", {31'd0, bus_valid}, 32'd0);
`else
        check("al_valid", {31'd0, bus_valid}, 32'd1);
        check("al_addr", bus_addr, 32'h102);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        check("al_ready", {31'd0, core_ready}, 32'd1);
        check("al_err", {31'd0, core_err}, 32'd0);
        check("al_rdata", core_rdata, 32'hCAFE_F00D);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
